axi_cfg_bridge_mc: RTL and testbench

AXI_CFG_BRIDGE_MC -- requirements
Module: axi_cfg_bridge_mc

---
 rtl/axi_cfg_bridge_mc_if.sv | 61 ++++++
 rtl/axi_cfg_bridge_mc.sv | 209 ++++++++++++++++++++
 tb/tb_axi_cfg_bridge_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cfg_bridge_mc_if.sv
// Bus bundle for axi_cfg_bridge_mc: AXI-lite slave side plus the shared multi-channel cfg master side.
// m_cfg_wr_strb exists only when AXI_CFG_WSTRB_EN is defined.
interface axi_cfg_bridge_mc_if #(
    parameter int NUM_CH         = 4,
    parameter int CFG_ADDR_WIDTH = 16,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]        s_axi_araddr;
    logic [AXI_ADDR_WIDTH-1:0]        s_axi_awaddr;
    logic                             s_axi_arvalid;
    logic                             s_axi_awvalid;
    logic                             s_axi_wvalid;
    logic                             s_axi_bready;
    logic                             s_axi_rready;
    logic                             s_axi_arready;
    logic                             s_axi_awready;
    logic                             s_axi_wready;
    logic                             s_axi_bvalid;
    logic                             s_axi_rvalid;
    logic [AXI_DATA_WIDTH-1:0]        s_axi_wdata;
    logic [3:0]                       s_axi_wstrb;
    logic [AXI_DATA_WIDTH-1:0]        s_axi_rdata;
    logic [1:0]                       s_axi_bresp;
    logic [1:0]                       s_axi_rresp;
    logic [CFG_ADDR_WIDTH-1:0]        m_cfg_addr;
    logic [CFG_DATA_WIDTH-1:0]        m_cfg_wr_data;
`ifdef AXI_CFG_WSTRB_EN
    logic [3:0]                       m_cfg_wr_strb;
`endif
    logic [NUM_CH-1:0]                m_cfg_wr_en;
    logic [NUM_CH-1:0]                m_cfg_rd_en;
    logic [NUM_CH-1:0]                m_cfg_busy;
    logic [NUM_CH-1:0]                m_cfg_rd_vld;
    logic [NUM_CH*CFG_DATA_WIDTH-1:0] m_cfg_rd_data;

    modport slave (
        input  s_axi_araddr, s_axi_awaddr, s_axi_arvalid, s_axi_awvalid, s_axi_wvalid,
        input  s_axi_bready, s_axi_rready, s_axi_wdata, s_axi_wstrb,
        output s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
        output s_axi_rdata, s_axi_bresp, s_axi_rresp,
`ifdef AXI_CFG_WSTRB_EN
        output m_cfg_wr_strb,
`endif
        output m_cfg_addr, m_cfg_wr_data, m_cfg_wr_en, m_cfg_rd_en,
        input  m_cfg_busy, m_cfg_rd_vld, m_cfg_rd_data
    );

    modport master (
        output s_axi_araddr, s_axi_awaddr, s_axi_arvalid, s_axi_awvalid, s_axi_wvalid,
        output s_axi_bready, s_axi_rready, s_axi_wdata, s_axi_wstrb,
        input  s_axi_arready, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_rvalid,
        input  s_axi_rdata, s_axi_bresp, s_axi_rresp,
`ifdef AXI_CFG_WSTRB_EN
        input  m_cfg_wr_strb,
`endif
        input  m_cfg_addr, m_cfg_wr_data, m_cfg_wr_en, m_cfg_rd_en,
        output m_cfg_busy, m_cfg_rd_vld, m_cfg_rd_data
    );
endinterface

// File: rtl/axi_cfg_bridge_mc.sv
// AXI-lite slave to multi-channel cfg bridge: one transaction at a time, non-posted writes, per-access timeout.
// Define AXI_CFG_WSTRB_EN to forward write strobes and skip all-zero-strobe writes.
module axi_cfg_bridge_mc #(
    parameter int NUM_CH         = 4,
    parameter int CFG_ADDR_WIDTH = 16,
    parameter int CFG_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CH_SEL_LSB     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               i_axi_clk,
    input  logic               i_axi_rst,
    axi_cfg_bridge_mc_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_DATA, CFG_WR, CFG_RD, WR_RESP, RD_DATA} state_t;

    state_t                    state_q;
    logic                      arready_q, awready_q, wready_q, bvalid_q, rvalid_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [CFG_ADDR_WIDTH-1:0] addr_q;
    logic [CFG_DATA_WIDTH-1:0] wdata_q;
    logic [NUM_CH-1:0]         wr_en_q, rd_en_q;
    logic [CH_W-1:0]           ch_q;
    logic                      dec_err_q, acc_q;
    logic [TMO_W-1:0]          tmo_q;

    logic                      sel_busy_d, sel_vld_d, tmo_hit_d;
    logic [CFG_DATA_WIDTH-1:0] sel_data_d;

    function automatic logic [CH_W-1:0] ch_of(input logic [AXI_ADDR_WIDTH-1:0] a);
        if (NUM_CH == 1) return '0;
        return a[CH_SEL_LSB +: CH_W];
    endfunction

    function automatic logic ch_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        return int'(ch_of(a)) < NUM_CH;
    endfunction

    always_comb begin
        sel_busy_d = bus.m_cfg_busy[ch_q];
        sel_vld_d  = bus.m_cfg_rd_vld[ch_q];
        sel_data_d = bus.m_cfg_rd_data[ch_q*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
        tmo_hit_d  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end

`ifdef AXI_CFG_WSTRB_EN
    logic [3:0] wstrb_q;
    assign bus.m_cfg_wr_strb = wstrb_q;
    logic unused_in;
    assign unused_in = ^{bus.s_axi_araddr, bus.s_axi_awaddr};
`else
    logic unused_in;
    assign unused_in = ^{bus.s_axi_araddr, bus.s_axi_awaddr, bus.s_axi_wstrb};
`endif

    always_ff @(posedge i_axi_clk) begin
        if (i_axi_rst) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= '0;
            rd_en_q   <= '0;
            ch_q      <= '0;
            dec_err_q <= 1'b0;
            acc_q     <= 1'b0;
            tmo_q     <= '0;
`ifdef AXI_CFG_WSTRB_EN
            wstrb_q   <= '0;
`endif
        end else begin
            case (state_q)
                // arready/awready are raised for one cycle; the handshake completes on the following edge
                IDLE: begin
                    if (arready_q) begin
                        arready_q <= 1'b0;
                        if (bus.s_axi_arvalid) begin
                            addr_q <= bus.s_axi_araddr[CFG_ADDR_WIDTH-1:0];
                            ch_q   <= ch_of(bus.s_axi_araddr);
                            if (ch_ok(bus.s_axi_araddr)) begin
                                rd_en_q <= NUM_CH'(1) << ch_of(bus.s_axi_araddr);
                                acc_q   <= 1'b0;
                                tmo_q   <= '0;
                                state_q <= CFG_RD;
                            end else begin
                                rvalid_q <= 1'b1;
                                rresp_q  <= RESP_DECERR;
                                rdata_q  <= '0;
                                state_q  <= RD_DATA;
                            end
                        end
                    end else if (awready_q) begin
                        awready_q <= 1'b0;
                        if (bus.s_axi_awvalid) begin
                            addr_q    <= bus.s_axi_awaddr[CFG_ADDR_WIDTH-1:0];
                            ch_q      <= ch_of(bus.s_axi_awaddr);
                            dec_err_q <= !ch_ok(bus.s_axi_awaddr);
                            wready_q  <= 1'b1;
                            state_q   <= WR_DATA;
                        end
                    end else if (bus.s_axi_arvalid) begin
                        arready_q <= 1'b1;
                    end else if (bus.s_axi_awvalid) begin
                        awready_q <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (bus.s_axi_wvalid) begin
                        wready_q <= 1'b0;
                        wdata_q  <= bus.s_axi_wdata;
`ifdef AXI_CFG_WSTRB_EN
                        wstrb_q  <= bus.s_axi_wstrb;
`endif
                        if (dec_err_q) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_DECERR;
                            state_q  <= WR_RESP;
                        end
`ifdef AXI_CFG_WSTRB_EN
                        else if (bus.s_axi_wstrb == 4'b0000) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= RESP_OKAY;
                            state_q  <= WR_RESP;
                        end
`endif
                        else begin
                            wr_en_q <= NUM_CH'(1) << ch_q;
                            tmo_q   <= '0;
                            state_q <= CFG_WR;
                        end
                    end
                end
                CFG_WR: begin
                    if (!sel_busy_d || tmo_hit_d) begin
                        wr_en_q  <= '0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= sel_busy_d ? RESP_SLVERR : RESP_OKAY;
                        state_q  <= WR_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                // Accepted once busy is low; rd_vld is honoured in that same cycle or any later one
                CFG_RD: begin
                    if ((acc_q || !sel_busy_d) && sel_vld_d) begin
                        rd_en_q  <= '0;
                        rdata_q  <= sel_data_d;
                        rresp_q  <= RESP_OKAY;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_DATA;
                    end else if (tmo_hit_d) begin
                        rd_en_q  <= '0;
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_DATA;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (!acc_q && !sel_busy_d) begin
                            rd_en_q <= '0;
                            acc_q   <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bus.s_axi_bready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (bus.s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_awready = awready_q;
    assign bus.s_axi_wready  = wready_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_rresp   = rresp_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.m_cfg_addr    = addr_q;
    assign bus.m_cfg_wr_data = wdata_q;
    assign bus.m_cfg_wr_en   = wr_en_q;
    assign bus.m_cfg_rd_en   = rd_en_q;
endmodule

// File: tb/tb_axi_cfg_bridge_mc.sv
// Directed bench for axi_cfg_bridge_mc: a 4-channel and a 3-channel instance, both with a 16-cycle timeout.
// Expectations for all-zero-strobe writes follow AXI_CFG_WSTRB_EN.
module tb_axi_cfg_bridge_mc;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    axi_cfg_bridge_mc_if #(.NUM_CH(4)) b4();
    axi_cfg_bridge_mc_if #(.NUM_CH(3)) b3();

    axi_cfg_bridge_mc #(.NUM_CH(4), .TIMEOUT_CYCLES(16)) dut4 (
        .i_axi_clk(clk), .i_axi_rst(rst), .bus(b4)
    );
    axi_cfg_bridge_mc #(.NUM_CH(3), .TIMEOUT_CYCLES(16)) dut3 (
        .i_axi_clk(clk), .i_axi_rst(rst), .bus(b3)
    );

    // Returns at the negedge right after the AR handshake edge.
    task automatic ar_req4(input logic [31:0] a);
        b4.s_axi_araddr  = a;
        b4.s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b4.s_axi_arready === 1'b1) break;
        end
        @(negedge clk);
        b4.s_axi_arvalid = 1'b0;
    endtask

    // Returns at the negedge right after the W handshake edge.
    task automatic aw_w4(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        b4.s_axi_awaddr  = a;
        b4.s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b4.s_axi_awready === 1'b1) break;
        end
        @(negedge clk);
        b4.s_axi_awvalid = 1'b0;
        b4.s_axi_wdata   = d;
        b4.s_axi_wstrb   = s;
        b4.s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (b4.s_axi_wready === 1'b1) break;
            @(negedge clk);
        end
        @(negedge clk);
        b4.s_axi_wvalid = 1'b0;
    endtask

    task automatic r_ack4();
        b4.s_axi_rready = 1'b1;
        @(negedge clk);
        b4.s_axi_rready = 1'b0;
    endtask

    task automatic b_ack4();
        b4.s_axi_bready = 1'b1;
        @(negedge clk);
        b4.s_axi_bready = 1'b0;
    endtask

    task automatic rd3(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                       output int strobes, output logic got);
        strobes = 0;
        got     = 1'b0;
        b3.s_axi_araddr  = a;
        b3.s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b3.s_axi_arready === 1'b1) break;
        end
        @(negedge clk);
        b3.s_axi_arvalid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (b3.m_cfg_rd_en !== 3'b000 || b3.m_cfg_wr_en !== 3'b000) strobes++;
            if (b3.s_axi_rvalid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        d = b3.s_axi_rdata;
        r = b3.s_axi_rresp;
        b3.s_axi_rready = 1'b1;
        @(negedge clk);
        b3.s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (b4.s_axi_arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%0h exp=0", b4.s_axi_arready); end
        checks++; if (b4.s_axi_awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%0h exp=0", b4.s_axi_awready); end
        checks++; if ({b4.s_axi_wready, b4.s_axi_bvalid, b4.s_axi_rvalid} !== 3'b000) begin failures++; $display("FAIL reset_valids got=%0h exp=0", {b4.s_axi_wready, b4.s_axi_bvalid, b4.s_axi_rvalid}); end
        checks++; if ({b4.m_cfg_wr_en, b4.m_cfg_rd_en} !== 8'h00) begin failures++; $display("FAIL reset_strobes got=%0h exp=0", {b4.m_cfg_wr_en, b4.m_cfg_rd_en}); end
        checks++; if (b4.m_cfg_addr !== 16'h0000) begin failures++; $display("FAIL reset_cfg_addr got=%0h exp=0", b4.m_cfg_addr); end
        checks++; if ({b4.s_axi_rdata, b4.s_axi_bresp, b4.s_axi_rresp} !== 36'h0) begin failures++; $display("FAIL reset_rdata_resp got=%0h exp=0", {b4.s_axi_rdata, b4.s_axi_bresp, b4.s_axi_rresp}); end
        checks++; if ({b3.m_cfg_rd_en, b3.s_axi_rvalid} !== 4'h0) begin failures++; $display("FAIL reset_dut3 got=%0h exp=0", {b3.m_cfg_rd_en, b3.s_axi_rvalid}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int n;
        b4.m_cfg_busy = 4'b0000;
        aw_w4(32'h0002_0010, 32'hA5A5_0001, 4'hF);
        checks++; if (b4.m_cfg_wr_en !== 4'b0100) begin failures++; $display("FAIL wr_en_onehot got=%0h exp=4", b4.m_cfg_wr_en); end
        checks++; if (b4.m_cfg_addr !== 16'h0010) begin failures++; $display("FAIL wr_cfg_addr got=%0h exp=10", b4.m_cfg_addr); end
        checks++; if (b4.m_cfg_wr_data !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_cfg_data got=%0h exp=a5a50001", b4.m_cfg_wr_data); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (b4.m_cfg_wr_en !== 4'b0000) n++;
            if (b4.s_axi_bvalid === 1'b1) break;
            @(negedge clk);
        end
        checks++; if (n !== 1) begin failures++; $display("FAIL wr_en_cycles got=%0d exp=1", n); end
        checks++; if (b4.s_axi_bvalid !== 1'b1) begin failures++; $display("FAIL wr_bvalid got=%0h exp=1", b4.s_axi_bvalid); end
        checks++; if (b4.s_axi_bresp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%0h exp=0", b4.s_axi_bresp); end
        b_ack4();
        checks++; if (b4.s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL wr_bvalid_clear got=%0h exp=0", b4.s_axi_bvalid); end
    endtask

    task automatic test_read();
        int   n;
        logic bad;
        b4.m_cfg_busy   = 4'b0010;
        b4.m_cfg_rd_vld = 4'b0000;
        ar_req4(32'h0001_0004);
        checks++; if (b4.m_cfg_addr !== 16'h0004) begin failures++; $display("FAIL rd_cfg_addr got=%0h exp=4", b4.m_cfg_addr); end
        n   = 0;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (b4.m_cfg_rd_en !== 4'b0000) begin
                n++;
                if (b4.m_cfg_rd_en !== 4'b0010) bad = 1'b1;
            end else if (n > 0) break;
            if (n == 4) b4.m_cfg_busy = 4'b0000;
            @(negedge clk);
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL rd_en_cycles got=%0d exp=4", n); end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rd_en_onehot got=%0h exp=0", bad); end
        @(negedge clk);
        b4.m_cfg_rd_vld  = 4'b0010;
        b4.m_cfg_rd_data = {32'h0, 32'h0, 32'h1234_5678, 32'h0};
        @(negedge clk);
        b4.m_cfg_rd_vld  = 4'b0000;
        for (int i = 0; i < 30 && b4.s_axi_rvalid !== 1'b1; i++) @(negedge clk);
        checks++; if (b4.s_axi_rvalid !== 1'b1) begin failures++; $display("FAIL rd_rvalid got=%0h exp=1", b4.s_axi_rvalid); end
        checks++; if (b4.s_axi_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rd_rdata got=%0h exp=12345678", b4.s_axi_rdata); end
        checks++; if (b4.s_axi_rresp !== 2'b00) begin failures++; $display("FAIL rd_rresp got=%0h exp=0", b4.s_axi_rresp); end
        r_ack4();
        checks++; if (b4.s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_clear got=%0h exp=0", b4.s_axi_rvalid); end
    endtask

    task automatic test_timeout();
        int n;
        b4.m_cfg_busy = 4'b0001;
        aw_w4(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (b4.m_cfg_wr_en !== 4'b0000) n++;
            if (b4.s_axi_bvalid === 1'b1) break;
            @(negedge clk);
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL tmo_wr_en_cycles got=%0d exp=16", n); end
        checks++; if (b4.s_axi_bresp !== 2'b10) begin failures++; $display("FAIL tmo_bresp got=%0h exp=2", b4.s_axi_bresp); end
        checks++; if (b4.m_cfg_wr_en !== 4'b0000) begin failures++; $display("FAIL tmo_wr_en_drop got=%0h exp=0", b4.m_cfg_wr_en); end
        b_ack4();
        b4.m_cfg_busy   = 4'b0000;
        b4.m_cfg_rd_vld = 4'b0000;
        ar_req4(32'h0000_0008);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (b4.s_axi_rvalid === 1'b1) break;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 16) begin failures++; $display("FAIL tmo_rd_wait got=%0d exp=16", n); end
        checks++; if (b4.s_axi_rresp !== 2'b10) begin failures++; $display("FAIL tmo_rresp got=%0h exp=2", b4.s_axi_rresp); end
        checks++; if (b4.s_axi_rdata !== 32'h0) begin failures++; $display("FAIL tmo_rdata got=%0h exp=0", b4.s_axi_rdata); end
        r_ack4();
    endtask

    task automatic test_back_to_back();
        int n;
        b4.m_cfg_busy    = 4'b0000;
        b4.m_cfg_rd_vld  = 4'b0100;
        b4.m_cfg_rd_data = {32'h0, 32'hCAFE_0002, 64'h0};
        b4.s_axi_araddr  = 32'h0002_0008;
        b4.s_axi_awaddr  = 32'h0003_0020;
        b4.s_axi_arvalid = 1'b1;
        b4.s_axi_awvalid = 1'b1;
        @(negedge clk);
        checks++; if ({b4.s_axi_arready, b4.s_axi_awready} !== 2'b10) begin failures++; $display("FAIL b2b_read_wins got=%0h exp=2", {b4.s_axi_arready, b4.s_axi_awready}); end
        @(negedge clk);
        b4.s_axi_arvalid = 1'b0;
        checks++; if (b4.m_cfg_rd_en !== 4'b0100) begin failures++; $display("FAIL b2b_rd_en got=%0h exp=4", b4.m_cfg_rd_en); end
        @(negedge clk);
        checks++; if ({b4.s_axi_rvalid, b4.m_cfg_rd_en} !== 5'b1_0000) begin failures++; $display("FAIL b2b_same_cycle_vld got=%0h exp=10", {b4.s_axi_rvalid, b4.m_cfg_rd_en}); end
        checks++; if (b4.s_axi_rdata !== 32'hCAFE_0002) begin failures++; $display("FAIL b2b_rdata got=%0h exp=cafe0002", b4.s_axi_rdata); end
        checks++; if (b4.s_axi_awready !== 1'b0) begin failures++; $display("FAIL b2b_awready_busy got=%0h exp=0", b4.s_axi_awready); end
        r_ack4();
        b4.m_cfg_rd_vld = 4'b0000;
        for (int i = 0; i < 10 && b4.s_axi_awready !== 1'b1; i++) @(negedge clk);
        checks++; if (b4.s_axi_awready !== 1'b1) begin failures++; $display("FAIL b2b_awready got=%0h exp=1", b4.s_axi_awready); end
        @(negedge clk);
        b4.s_axi_awvalid = 1'b0;
        b4.s_axi_wdata   = 32'h0BAD_F00D;
        b4.s_axi_wstrb   = 4'hF;
        b4.s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 10 && b4.s_axi_wready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        b4.s_axi_wvalid = 1'b0;
        checks++; if (b4.m_cfg_wr_en !== 4'b1000) begin failures++; $display("FAIL b2b_wr_en got=%0h exp=8", b4.m_cfg_wr_en); end
        for (int i = 0; i < 20 && b4.s_axi_bvalid !== 1'b1; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (b4.s_axi_bvalid === 1'b1) n++;
            if (i == 4) b4.s_axi_bready = 1'b1;
            @(negedge clk);
        end
        b4.s_axi_bready = 1'b0;
        checks++; if (n !== 5) begin failures++; $display("FAIL b2b_bvalid_hold got=%0d exp=5", n); end
        checks++; if (b4.s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL b2b_bvalid_clear got=%0h exp=0", b4.s_axi_bvalid); end
    endtask

    task automatic test_decerr();
        logic [31:0] d;
        logic [1:0]  r;
        int          s;
        logic        got;
        b3.m_cfg_busy    = 3'b000;
        b3.m_cfg_rd_vld  = 3'b111;
        b3.m_cfg_rd_data = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        rd3(32'h0002_0000, d, r, s, got);
        checks++; if ({got, r, s[1:0]} !== 5'b1_00_01) begin failures++; $display("FAIL dec_ok_read got=%0h exp=11", {got, r, s[1:0]}); end
        checks++; if (d !== 32'h3333_0002) begin failures++; $display("FAIL dec_ok_rdata got=%0h exp=33330002", d); end
        rd3(32'h0003_0000, d, r, s, got);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL dec_rvalid got=%0h exp=1", got); end
        checks++; if (r !== 2'b11) begin failures++; $display("FAIL dec_rresp got=%0h exp=3", r); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL dec_rdata got=%0h exp=0", d); end
        checks++; if (s !== 0) begin failures++; $display("FAIL dec_rd_strobes got=%0d exp=0", s); end
        b3.s_axi_awaddr  = 32'h0003_0004;
        b3.s_axi_awvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (b3.s_axi_awready === 1'b1) break; end
        @(negedge clk);
        b3.s_axi_awvalid = 1'b0;
        b3.s_axi_wdata   = 32'h7777_7777;
        b3.s_axi_wstrb   = 4'hF;
        b3.s_axi_wvalid  = 1'b1;
        for (int i = 0; i < 20 && b3.s_axi_wready !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        b3.s_axi_wvalid = 1'b0;
        s = 0;
        for (int i = 0; i < 30; i++) begin
            if (b3.m_cfg_wr_en !== 3'b000) s++;
            if (b3.s_axi_bvalid === 1'b1) break;
            @(negedge clk);
        end
        checks++; if ({b3.s_axi_bvalid, b3.s_axi_bresp} !== 3'b1_11) begin failures++; $display("FAIL dec_bresp got=%0h exp=7", {b3.s_axi_bvalid, b3.s_axi_bresp}); end
        checks++; if (s !== 0) begin failures++; $display("FAIL dec_wr_strobes got=%0d exp=0", s); end
        b3.s_axi_bready = 1'b1;
        @(negedge clk);
        b3.s_axi_bready = 1'b0;
    endtask

    task automatic test_wstrb();
        int n;
        int exp_n;
`ifdef AXI_CFG_WSTRB_EN
        exp_n = 0;
`else
        exp_n = 1;
`endif
        b4.m_cfg_busy = 4'b0000;
        aw_w4(32'h0003_0040, 32'h1111_2222, 4'b0000);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (b4.m_cfg_wr_en !== 4'b0000) n++;
            if (b4.s_axi_bvalid === 1'b1) break;
            @(negedge clk);
        end
        checks++; if (n !== exp_n) begin failures++; $display("FAIL wstrb0_wr_en_cycles got=%0d exp=%0d", n, exp_n); end
        checks++; if ({b4.s_axi_bvalid, b4.s_axi_bresp} !== 3'b1_00) begin failures++; $display("FAIL wstrb0_bresp got=%0h exp=4", {b4.s_axi_bvalid, b4.s_axi_bresp}); end
        b_ack4();
`ifdef AXI_CFG_WSTRB_EN
        aw_w4(32'h0003_0044, 32'h3333_4444, 4'b0110);
        checks++; if ({b4.m_cfg_wr_en, b4.m_cfg_wr_strb} !== 8'b1000_0110) begin failures++; $display("FAIL wstrb_forward got=%0h exp=86", {b4.m_cfg_wr_en, b4.m_cfg_wr_strb}); end
        for (int i = 0; i < 20 && b4.s_axi_bvalid !== 1'b1; i++) @(negedge clk);
        b_ack4();
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        b4.m_cfg_busy   = 4'b0010;
        b4.m_cfg_rd_vld = 4'b0000;
        ar_req4(32'h0001_0020);
        checks++; if (b4.m_cfg_rd_en !== 4'b0010) begin failures++; $display("FAIL mid_rd_en got=%0h exp=2", b4.m_cfg_rd_en); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({b4.m_cfg_rd_en, b4.s_axi_rvalid} !== 5'b0) begin failures++; $display("FAIL mid_abandon got=%0h exp=0", {b4.m_cfg_rd_en, b4.s_axi_rvalid}); end
        checks++; if ({b4.s_axi_rdata, b4.m_cfg_addr} !== 48'h0) begin failures++; $display("FAIL mid_regs_cleared got=%0h exp=0", {b4.s_axi_rdata, b4.m_cfg_addr}); end
        b4.m_cfg_busy    = 4'b0000;
        b4.m_cfg_rd_vld  = 4'b0010;
        b4.m_cfg_rd_data = {32'h0, 32'h0, 32'h5555_AAAA, 32'h0};
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (b4.s_axi_rvalid !== 1'b0 || b4.m_cfg_rd_en !== 4'b0000) n++;
            @(negedge clk);
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL mid_silent got=%0d exp=0", n); end
        ar_req4(32'h0001_0024);
        for (int i = 0; i < 30 && b4.s_axi_rvalid !== 1'b1; i++) @(negedge clk);
        checks++; if ({b4.s_axi_rvalid, b4.s_axi_rresp} !== 3'b1_00) begin failures++; $display("FAIL mid_next_resp got=%0h exp=4", {b4.s_axi_rvalid, b4.s_axi_rresp}); end
        checks++; if (b4.s_axi_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL mid_next_rdata got=%0h exp=5555aaaa", b4.s_axi_rdata); end
        r_ack4();
        b4.m_cfg_rd_vld = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        b4.s_axi_araddr = '0; b4.s_axi_awaddr = '0; b4.s_axi_arvalid = 1'b0; b4.s_axi_awvalid = 1'b0;
        b4.s_axi_wvalid = 1'b0; b4.s_axi_bready = 1'b0; b4.s_axi_rready = 1'b0;
        b4.s_axi_wdata = '0; b4.s_axi_wstrb = '0;
        b4.m_cfg_busy = '0; b4.m_cfg_rd_vld = '0; b4.m_cfg_rd_data = '0;
        b3.s_axi_araddr = '0; b3.s_axi_awaddr = '0; b3.s_axi_arvalid = 1'b0; b3.s_axi_awvalid = 1'b0;
        b3.s_axi_wvalid = 1'b0; b3.s_axi_bready = 1'b0; b3.s_axi_rready = 1'b0;
        b3.s_axi_wdata = '0; b3.s_axi_wstrb = '0;
        b3.m_cfg_busy = '0; b3.m_cfg_rd_vld = '0; b3.m_cfg_rd_data = '0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_back_to_back();
        test_decerr();
        test_wstrb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
